// File: rtl/spi_master_txn_sequencer_if.sv
// Host and SPI-master side signals of the transaction sequencer.
// The master modport is the sequencer's view; slave is the host plus SPI master core.
interface spi_master_txn_sequencer_if #(
  parameter int N     = 8,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [N-1:0]  tx_data_i;
  logic          tx_valid_i;
  logic          tx_ready_o;
  logic [N-1:0]  rx_data_o;
  logic          rx_valid_o;
  logic          rx_ready_i;
  logic          start_o;
  logic [N-1:0]  spi_data_o;
  logic          done_i;
  logic [N-1:0]  spi_rx_i;
  logic          busy_o;
  logic          timeout_err_o;
  logic [LW-1:0] tx_level_o;
  logic [LW-1:0] rx_level_o;

  modport master (
    input  tx_data_i, tx_valid_i, rx_ready_i, done_i, spi_rx_i,
    output tx_ready_o, rx_data_o, rx_valid_o, start_o, spi_data_o,
           busy_o, timeout_err_o, tx_level_o, rx_level_o
  );

  modport slave (
    output tx_data_i, tx_valid_i, rx_ready_i, done_i, spi_rx_i,
    input  tx_ready_o, rx_data_o, rx_valid_o, start_o, spi_data_o,
           busy_o, timeout_err_o, tx_level_o, rx_level_o
  );
endinterface

// File: rtl/spi_master_txn_sequencer.sv
// TX FIFO -> one SPI master transfer per byte -> RX FIFO, with a per-transfer timeout.
// spi_data_o is loaded on the IDLE->LOAD edge so it is already stable while start_o is high.
module spi_master_txn_sequencer #(
  parameter int N       = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input logic                     clk_c,
  input logic                     reset_r,
  spi_master_txn_sequencer_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  tx_mem_q [DEPTH];
  logic [N-1:0]  tx_mem_d [DEPTH];
  logic [N-1:0]  rx_mem_q [DEPTH];
  logic [N-1:0]  rx_mem_d [DEPTH];
  logic [AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [LW-1:0] tx_level_q, tx_level_d, rx_level_q, rx_level_d;
  logic [N-1:0]  spi_data_q, spi_data_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          timeout_err_q, timeout_err_d;

  logic tx_full, rx_full, tx_push, tx_pop, rx_push, rx_pop;

  assign tx_full = (tx_level_q == LW'(DEPTH));
  assign rx_full = (rx_level_q == LW'(DEPTH));
  assign tx_push = bus.tx_valid_i && !tx_full;
  assign rx_pop  = bus.rx_ready_i && (rx_level_q != '0);

  always_comb begin
    state_d       = state_q;
    spi_data_d    = spi_data_q;
    timer_d       = timer_q;
    timeout_err_d = timeout_err_q;
    tx_pop        = 1'b0;
    rx_push       = 1'b0;
    case (state_q)
      S_IDLE: begin
        // RX space is reserved before launching, so the returned byte always fits
        if ((tx_level_q != '0) && !rx_full && !bus.done_i) begin
          state_d    = S_LOAD;
          tx_pop     = 1'b1;
          spi_data_d = tx_mem_q[tx_rptr_q];
        end
      end
      S_LOAD: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        if (bus.done_i) begin
          rx_push = 1'b1;
          state_d = S_IDLE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_mem_d  = tx_mem_q;
    rx_mem_d  = rx_mem_q;
    tx_wptr_d = tx_push ? tx_wptr_q + AW'(1) : tx_wptr_q;
    tx_rptr_d = tx_pop  ? tx_rptr_q + AW'(1) : tx_rptr_q;
    rx_wptr_d = (rx_push && !rx_full) ? rx_wptr_q + AW'(1) : rx_wptr_q;
    rx_rptr_d = rx_pop  ? rx_rptr_q + AW'(1) : rx_rptr_q;
    if (tx_push) tx_mem_d[tx_wptr_q] = bus.tx_data_i;
    if (rx_push && !rx_full) rx_mem_d[rx_wptr_q] = bus.spi_rx_i;
    tx_level_d = tx_level_q;
    case ({tx_push, tx_pop})
      2'b10:   tx_level_d = tx_level_q + LW'(1);
      2'b01:   tx_level_d = tx_level_q - LW'(1);
      default: tx_level_d = tx_level_q;
    endcase
    rx_level_d = rx_level_q;
    case ({rx_push && !rx_full, rx_pop})
      2'b10:   rx_level_d = rx_level_q + LW'(1);
      2'b01:   rx_level_d = rx_level_q - LW'(1);
      default: rx_level_d = rx_level_q;
    endcase
  end

  always_ff @(posedge clk_c) begin
    if (reset_r) begin
      state_q       <= S_IDLE;
      tx_wptr_q     <= '0;
      tx_rptr_q     <= '0;
      rx_wptr_q     <= '0;
      rx_rptr_q     <= '0;
      tx_level_q    <= '0;
      rx_level_q    <= '0;
      spi_data_q    <= '0;
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_wptr_q     <= tx_wptr_d;
      tx_rptr_q     <= tx_rptr_d;
      rx_wptr_q     <= rx_wptr_d;
      rx_rptr_q     <= rx_rptr_d;
      tx_level_q    <= tx_level_d;
      rx_level_q    <= rx_level_d;
      spi_data_q    <= spi_data_d;
      timer_q       <= timer_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Storage needs no reset: levels gate every read
  always_ff @(posedge clk_c) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
  end

  assign bus.tx_ready_o    = !tx_full;
  assign bus.rx_data_o     = rx_mem_q[rx_rptr_q];
  assign bus.rx_valid_o    = (rx_level_q != '0);
  assign bus.start_o       = (state_q == S_LOAD);
  assign bus.spi_data_o    = spi_data_q;
  assign bus.busy_o        = (state_q != S_IDLE);
  assign bus.timeout_err_o = timeout_err_q;
  assign bus.tx_level_o    = tx_level_q;
  assign bus.rx_level_o    = rx_level_q;
endmodule

// File: tb/tb_spi_master_txn_sequencer.sv
// Directed bench: behavioural SPI master answers each start with (byte ^ 0x99).
module tb_spi_master_txn_sequencer;
  localparam int N = 8, DEPTH = 4, TIMEOUT = 16;

  logic clk_c = 1'b0;
  logic reset_r = 1'b1;
  always #5 clk_c = ~clk_c;

  spi_master_txn_sequencer_if #(.N(N), .DEPTH(DEPTH)) bus ();
  spi_master_txn_sequencer #(.N(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_c(clk_c), .reset_r(reset_r), .bus(bus.master));

  int checks = 0, errors = 0;
  logic master_done = 1'b0, hold_done = 1'b0;
  logic [N-1:0] master_rx = '0;
  int lat = 2, hold = 1;
  bit stall = 1'b0;
  int start_cnt = 0;
  logic [N-1:0] start_log[$];

  assign bus.done_i   = master_done | hold_done;
  assign bus.spi_rx_i = master_rx;

  initial begin
    logic [N-1:0] m_data;
    forever begin
      @(negedge clk_c);
      if (bus.start_o === 1'b1 && !stall) begin
        m_data = bus.spi_data_o;
        repeat (lat) @(negedge clk_c);
        master_done = 1'b1; master_rx = m_data ^ 8'h99;
        repeat (hold) @(negedge clk_c);
        master_done = 1'b0; master_rx = '0;
      end
    end
  end

  initial forever begin
    @(negedge clk_c);
    if (bus.start_o === 1'b1) begin start_cnt++; start_log.push_back(bus.spi_data_o); end
  end

  task automatic push1(input logic [N-1:0] b);
    @(negedge clk_c); bus.tx_valid_i = 1'b1; bus.tx_data_i = b;
    @(negedge clk_c); bus.tx_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    bus.tx_valid_i = 0; bus.tx_data_i = '0; bus.rx_ready_i = 0;
    reset_r = 1'b1; repeat (2) @(negedge clk_c); reset_r = 1'b0;
    checks++; if (bus.start_o !== 1'b0) begin errors++; $display("FAIL rst_start got %0h exp 0", bus.start_o); end
    checks++; if (bus.spi_data_o !== 8'h00) begin errors++; $display("FAIL rst_spi_data got %0h exp 0", bus.spi_data_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %0h exp 0", bus.busy_o); end
    checks++; if (bus.timeout_err_o !== 1'b0) begin errors++; $display("FAIL rst_err got %0h exp 0", bus.timeout_err_o); end
    checks++; if (bus.tx_ready_o !== 1'b1) begin errors++; $display("FAIL rst_tx_ready got %0h exp 1", bus.tx_ready_o); end
    checks++; if (bus.rx_valid_o !== 1'b0) begin errors++; $display("FAIL rst_rx_valid got %0h exp 0", bus.rx_valid_o); end
    checks++; if (bus.tx_level_o !== 3'd0) begin errors++; $display("FAIL rst_tx_level got %0d exp 0", bus.tx_level_o); end
    checks++; if (bus.rx_level_o !== 3'd0) begin errors++; $display("FAIL rst_rx_level got %0d exp 0", bus.rx_level_o); end
  endtask

  task automatic test_single();
    int base; bit held; bit got;
    lat = 10; hold = 1; stall = 0; base = start_cnt;
    @(negedge clk_c); bus.tx_valid_i = 1'b1; bus.tx_data_i = 8'hA5;
    @(negedge clk_c); bus.tx_valid_i = 1'b0;
    checks++; if (bus.tx_level_o !== 3'd1) begin errors++; $display("FAIL single_tx_level got %0d exp 1", bus.tx_level_o); end
    checks++; if (bus.start_o !== 1'b0) begin errors++; $display("FAIL single_start_early got %0h exp 0", bus.start_o); end
    @(negedge clk_c);
    checks++; if (bus.start_o !== 1'b1) begin errors++; $display("FAIL single_start got %0h exp 1", bus.start_o); end
    checks++; if (bus.spi_data_o !== 8'hA5) begin errors++; $display("FAIL single_spi_data got %0h exp a5", bus.spi_data_o); end
    held = 1; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk_c);
      if (bus.rx_valid_o === 1'b1) got = 1;
      else if (bus.spi_data_o !== 8'hA5) held = 0;
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL single_rx_wait got %0h exp 1", got); end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL single_data_held got %0h exp 1", held); end
    checks++; if (bus.rx_data_o !== 8'h3C) begin errors++; $display("FAIL single_rx_data got %0h exp 3c", bus.rx_data_o); end
    checks++; if (bus.rx_level_o !== 3'd1) begin errors++; $display("FAIL single_rx_level got %0d exp 1", bus.rx_level_o); end
    checks++; if (start_cnt - base !== 1) begin errors++; $display("FAIL single_start_cnt got %0d exp 1", start_cnt - base); end
    bus.rx_ready_i = 1'b1; @(negedge clk_c); bus.rx_ready_i = 1'b0;
    checks++; if (bus.rx_level_o !== 3'd0) begin errors++; $display("FAIL single_pop got %0d exp 0", bus.rx_level_o); end
  endtask

  task automatic test_fill();
    logic [N-1:0] b [5];
    int base;
    b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    hold_done = 1'b1; lat = 2; hold = 1; base = start_log.size();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_c);
      if (i == 4) begin
        checks++; if (bus.tx_ready_o !== 1'b0) begin errors++; $display("FAIL fill_ready_5th got %0h exp 0", bus.tx_ready_o); end
      end
      bus.tx_valid_i = 1'b1; bus.tx_data_i = b[i];
    end
    @(negedge clk_c); bus.tx_valid_i = 1'b0;
    checks++; if (bus.tx_level_o !== 3'd4) begin errors++; $display("FAIL fill_tx_level got %0d exp 4", bus.tx_level_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL fill_busy_stalled got %0h exp 0", bus.busy_o); end
    hold_done = 1'b0;
    for (int i = 0; i < 200 && bus.rx_level_o !== 3'd4; i++) @(negedge clk_c);
    checks++; if (bus.rx_level_o !== 3'd4) begin errors++; $display("FAIL fill_rx_level got %0d exp 4", bus.rx_level_o); end
    checks++; if (start_log.size() - base !== 4) begin errors++; $display("FAIL fill_starts got %0d exp 4", start_log.size() - base); end
    for (int k = 0; k < 4 && base + k < start_log.size(); k++) begin
      checks++; if (start_log[base+k] !== b[k]) begin errors++; $display("FAIL fill_order[%0d] got %0h exp %0h", k, start_log[base+k], b[k]); end
    end
    checks++; if (bus.tx_level_o !== 3'd0) begin errors++; $display("FAIL fill_tx_drained got %0d exp 0", bus.tx_level_o); end
  endtask

  task automatic test_rx_full();
    logic [N-1:0] e [4];
    int base; bit fired;
    e = '{8'hBB, 8'hAA, 8'hDD, 8'hFF};
    base = start_cnt;
    push1(8'h66);
    repeat (5) @(negedge clk_c);
    checks++; if (bus.tx_level_o !== 3'd1) begin errors++; $display("FAIL rxfull_tx_level got %0d exp 1", bus.tx_level_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rxfull_busy got %0h exp 0", bus.busy_o); end
    checks++; if (start_cnt !== base) begin errors++; $display("FAIL rxfull_no_start got %0d exp %0d", start_cnt, base); end
    checks++; if (bus.rx_data_o !== 8'h88) begin errors++; $display("FAIL rxfull_head got %0h exp 88", bus.rx_data_o); end
    bus.rx_ready_i = 1'b1; @(negedge clk_c); bus.rx_ready_i = 1'b0;
    checks++; if (bus.rx_level_o !== 3'd3) begin errors++; $display("FAIL rxfull_after_pop got %0d exp 3", bus.rx_level_o); end
    fired = 0;
    for (int i = 0; i < 2; i++) begin @(negedge clk_c); if (bus.start_o === 1'b1) fired = 1; end
    checks++; if (fired !== 1'b1) begin errors++; $display("FAIL rxfull_start_after_pop got %0h exp 1", fired); end
    for (int i = 0; i < 50 && bus.rx_level_o !== 3'd4; i++) @(negedge clk_c);
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.rx_data_o !== e[k]) begin errors++; $display("FAIL rxfull_drain[%0d] got %0h exp %0h", k, bus.rx_data_o, e[k]); end
      bus.rx_ready_i = 1'b1; @(negedge clk_c);
    end
    bus.rx_ready_i = 1'b0;
    checks++; if (bus.rx_level_o !== 3'd0) begin errors++; $display("FAIL rxfull_empty got %0d exp 0", bus.rx_level_o); end
  endtask

  task automatic test_done_level();
    bit ok;
    lat = 2; hold = 3;
    @(negedge clk_c); bus.tx_valid_i = 1'b1; bus.tx_data_i = 8'h12;
    @(negedge clk_c); bus.tx_data_i = 8'h34;
    @(negedge clk_c); bus.tx_valid_i = 1'b0;
    for (int i = 0; i < 30 && bus.rx_level_o !== 3'd1; i++) @(negedge clk_c);
    checks++; if (bus.rx_level_o !== 3'd1) begin errors++; $display("FAIL lvl_first_entry got %0d exp 1", bus.rx_level_o); end
    ok = (bus.start_o === 1'b0);
    repeat (2) begin
      @(negedge clk_c);
      if (bus.start_o !== 1'b0 || bus.rx_level_o !== 3'd1) ok = 0;
    end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL lvl_single_entry got %0h exp 1", ok); end
    @(negedge clk_c);
    checks++; if (bus.start_o !== 1'b1) begin errors++; $display("FAIL lvl_next_start got %0h exp 1", bus.start_o); end
    checks++; if (bus.rx_level_o !== 3'd1) begin errors++; $display("FAIL lvl_still_one got %0d exp 1", bus.rx_level_o); end
    for (int i = 0; i < 30 && bus.rx_level_o !== 3'd2; i++) @(negedge clk_c);
    repeat (4) @(negedge clk_c);
    checks++; if (bus.rx_level_o !== 3'd2) begin errors++; $display("FAIL lvl_two_entries got %0d exp 2", bus.rx_level_o); end
    checks++; if (bus.rx_data_o !== 8'h8B) begin errors++; $display("FAIL lvl_rx0 got %0h exp 8b", bus.rx_data_o); end
    bus.rx_ready_i = 1'b1; @(negedge clk_c); bus.rx_ready_i = 1'b0;
    checks++; if (bus.rx_data_o !== 8'hAD) begin errors++; $display("FAIL lvl_rx1 got %0h exp ad", bus.rx_data_o); end
    bus.rx_ready_i = 1'b1; @(negedge clk_c); bus.rx_ready_i = 1'b0;
    hold = 1;
  endtask

  task automatic test_timeout();
    stall = 1'b1;
    @(negedge clk_c); bus.tx_valid_i = 1'b1; bus.tx_data_i = 8'h77;
    @(negedge clk_c); bus.tx_valid_i = 1'b0;
    for (int i = 0; i < 10 && bus.start_o !== 1'b1; i++) @(negedge clk_c);
    checks++; if (bus.start_o !== 1'b1) begin errors++; $display("FAIL to_start got %0h exp 1", bus.start_o); end
    repeat (TIMEOUT) @(negedge clk_c);
    checks++; if (bus.timeout_err_o !== 1'b0 || bus.busy_o !== 1'b1) begin errors++; $display("FAIL to_early err=%0h busy=%0h exp err=0 busy=1", bus.timeout_err_o, bus.busy_o); end
    @(negedge clk_c);
    checks++; if (bus.timeout_err_o !== 1'b1) begin errors++; $display("FAIL to_err got %0h exp 1", bus.timeout_err_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL to_idle got %0h exp 0", bus.busy_o); end
    checks++; if (bus.rx_level_o !== 3'd0) begin errors++; $display("FAIL to_no_rx got %0d exp 0", bus.rx_level_o); end
    stall = 1'b0; lat = 3; hold = 1;
    push1(8'h5A);
    for (int i = 0; i < 40 && bus.rx_valid_o !== 1'b1; i++) @(negedge clk_c);
    checks++; if (bus.rx_data_o !== 8'hC3 || bus.rx_valid_o !== 1'b1) begin errors++; $display("FAIL to_next_rx got %0h/%0h exp c3/1", bus.rx_data_o, bus.rx_valid_o); end
    checks++; if (bus.timeout_err_o !== 1'b1) begin errors++; $display("FAIL to_sticky got %0h exp 1", bus.timeout_err_o); end
    bus.rx_ready_i = 1'b1; @(negedge clk_c); bus.rx_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    int base;
    stall = 1'b1; hold_done = 1'b1;
    for (int i = 0; i < 4; i++) begin @(negedge clk_c); bus.tx_valid_i = 1'b1; bus.tx_data_i = N'(i + 1); end
    @(negedge clk_c); bus.tx_valid_i = 1'b0; hold_done = 1'b0;
    for (int i = 0; i < 10 && bus.start_o !== 1'b1; i++) @(negedge clk_c);
    repeat (3) @(negedge clk_c);
    checks++; if (bus.tx_level_o !== 3'd3 || bus.busy_o !== 1'b1) begin errors++; $display("FAIL rmid_pre level=%0d busy=%0h exp 3/1", bus.tx_level_o, bus.busy_o); end
    reset_r = 1'b1; @(negedge clk_c);
    checks++; if (bus.start_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.spi_data_o !== 8'h00) begin errors++; $display("FAIL rmid_fsm start=%0h busy=%0h data=%0h exp 0/0/0", bus.start_o, bus.busy_o, bus.spi_data_o); end
    checks++; if (bus.timeout_err_o !== 1'b0) begin errors++; $display("FAIL rmid_err got %0h exp 0", bus.timeout_err_o); end
    checks++; if (bus.tx_level_o !== 3'd0 || bus.tx_ready_o !== 1'b1) begin errors++; $display("FAIL rmid_tx level=%0d ready=%0h exp 0/1", bus.tx_level_o, bus.tx_ready_o); end
    checks++; if (bus.rx_level_o !== 3'd0 || bus.rx_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_rx level=%0d valid=%0h exp 0/0", bus.rx_level_o, bus.rx_valid_o); end
    reset_r = 1'b0; base = start_cnt;
    repeat (20) @(negedge clk_c);
    checks++; if (bus.rx_level_o !== 3'd0 || bus.busy_o !== 1'b0 || start_cnt !== base) begin errors++; $display("FAIL rmid_quiet rx=%0d busy=%0h starts=%0d exp 0/0/%0d", bus.rx_level_o, bus.busy_o, start_cnt, base); end
    stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_rx_full();
    test_done_level();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
